alu_issue_ctrl: RTL and testbench

//   Issue-side controller for the 64-bit ALU. Accepts operations (opcode, two operands, tag) over a

---
 rtl/alu_pkg.sv | 11 +
 rtl/alu_result_fifo.sv | 56 +++++
 rtl/alu_issue_ctrl.sv | 111 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU result-select encodings
package alu_pkg;

  localparam int ALU_SEL_W = 2;

  localparam logic [ALU_SEL_W-1:0] ALU_OP_CMP  = 2'b00;
  localparam logic [ALU_SEL_W-1:0] ALU_OP_PASS = 2'b01;
  localparam logic [ALU_SEL_W-1:0] ALU_OP_XOR  = 2'b10;
  localparam logic [ALU_SEL_W-1:0] ALU_OP_ADD  = 2'b11;

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - in-order result queue with occupancy count
module alu_result_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Storage array; no reset needed because reads are masked while empty.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap at DEPTH-1 so non-power-of-two depths also work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o    = (count_q != '0);
  assign pop_data_o = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - ALU issue controller with credit-protected result queue
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH        = 64,
  parameter int TAG_W        = 4,
  parameter int ALU_LATENCY  = 0,
  parameter int RESULT_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           in_op_i,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  input  logic [TAG_W-1:0]     in_tag_i,
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  output logic [ALU_SEL_W-1:0] alu_select_o,
  input  logic [WIDTH-1:0]     alu_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [TAG_W-1:0]     out_tag_o,
  output logic                 idle_o
);

  localparam int CNT_W = $clog2(RESULT_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic             accept;
  logic             push;
  logic             pop;
  logic             vld_q [ALU_LATENCY+1];
  logic [TAG_W-1:0] tag_q [ALU_LATENCY+1];
  logic [CNT_W-1:0] inflight_q;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] used;
  logic [WIDTH+TAG_W-1:0] head;

  assign accept = in_valid_i & in_ready_o;
  assign push   = vld_q[ALU_LATENCY];
  assign pop    = out_valid_o & out_ready_i;

  // Operand/select registers load only on accept so the ALU inputs never toggle while idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_a_o      <= '0;
      alu_b_o      <= '0;
      alu_select_o <= '0;
    end else if (accept) begin
      alu_a_o      <= in_a_i;
      alu_b_o      <= in_b_i;
      alu_select_o <= in_op_i;
    end
  end

  // Valid/tag shift line aligned with the ALU so the last stage marks the result-sample cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k <= ALU_LATENCY; k++) begin
        vld_q[k] <= 1'b0;
        tag_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      tag_q[0] <= in_tag_i;
      for (int k = 1; k <= ALU_LATENCY; k++) begin
        vld_q[k] <= vld_q[k-1];
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  // Operations accepted but not yet written into the result queue.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q <= '0;
    end else begin
      unique case ({accept, push})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  alu_result_fifo #(
    .WIDTH (WIDTH + TAG_W),
    .DEPTH (RESULT_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i ({tag_q[ALU_LATENCY], alu_result_i}),
    .pop_i       (pop),
    .pop_data_o  (head),
    .valid_o     (out_valid_o),
    .count_o     (count)
  );

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign used       = {1'b0, count} + {1'b0, inflight_q};
  assign in_ready_o = (used < SUM_W'(RESULT_DEPTH));
  assign out_data_o = head[WIDTH-1:0];
  assign out_tag_o  = head[WIDTH+TAG_W-1:WIDTH];
  assign idle_o     = (inflight_q == '0) && (count == '0);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic        clk;
  logic        rst_ni;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [3:0]  in_tag;
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alu_select;
  logic [63:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_tag;
  logic        idle;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   pop_cnt = 0;

  alu_issue_ctrl #(
    .WIDTH(64), .TAG_W(4), .ALU_LATENCY(0), .RESULT_DEPTH(4)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_op_i(in_op), .in_a_i(in_a), .in_b_i(in_b), .in_tag_i(in_tag),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_select_o(alu_select),
    .alu_result_i(alu_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .idle_o(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] alu_model(input logic [1:0] sel, input logic [63:0] a,
                                            input logic [63:0] b);
    case (sel)
      ALU_OP_CMP:  return {63'b0, (a < b)};
      ALU_OP_PASS: return a;
      ALU_OP_XOR:  return a ^ b;
      default:     return a + b;
    endcase
  endfunction

  // Combinational ALU stub driven from the controller's operand registers.
  always_comb alu_result = alu_model(alu_select, alu_a, alu_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard: compare pops against the queue, then enqueue the expected result of any accept.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (out_valid && out_ready) begin
        pop_cnt++;
        check("sb_entry_present", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("out_data", out_data, e.data);
          check("out_tag", 64'(out_tag), 64'(e.tag));
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.data = alu_model(in_op, in_a, in_b);
        n.tag  = in_tag;
        sb_q.push_back(n);
      end
    end
  end

  task automatic drive(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic send(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [3:0] tag);
    logic ok;
    ok = 1'b0;
    drive(op, a, b, tag);
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (idle && sb_q.size() == 0) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("drain", 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    int p0;
    logic ok;
    rst_ni = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;

    // Reset asserted mid-clock
    #3 rst_ni = 1'b0;
    #1;
    check("rst_alu_a", alu_a, 64'd0);
    check("rst_alu_b", alu_b, 64'd0);
    check("rst_sel", 64'(alu_select), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);
    check("rel_idle", 64'(idle), 64'd1);

    // Single add wrapping to zero
    send(ALU_OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd3);
    in_valid = 1'b0;
    check("add_sel", 64'(alu_select), 64'(ALU_OP_ADD));
    check("add_valid_early", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_data", out_data, 64'd0);
    check("add_tag", 64'(out_tag), 64'd3);
    @(posedge clk);
    #1;
    check("add_idle", 64'(idle), 64'd1);

    // Streaming: 8 back-to-back ops
    p0 = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(2'((i + 2) % 4), {$urandom, $urandom}, {$urandom, $urandom}, 4'(i));
      check("stream_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("stream_pops", 64'(pop_cnt - p0), 64'd8);
    wait_drain();

    // Backpressure: credits stop acceptance at queue depth
    out_ready = 1'b0;
    idx = 0;
    p0 = pop_cnt;
    for (int c = 0; c < 14; c++) begin
      drive(2'(idx % 4), {$urandom, $urandom}, 64'(idx * 7 + 1), 4'(idx + 8));
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd4);
    check("bp_ready_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_ready_back", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    wait_drain();
    check("bp_pops", 64'(pop_cnt - p0), 64'd4);

    // Reset with work in flight and queued
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(2'(i), 64'(i + 100), 64'(i + 3), 4'(i + 4));
    in_valid = 1'b0;
    #3 rst_ni = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_idle", 64'(idle), 64'd1);
    sb_q.delete();
    @(posedge clk);
    #1 rst_ni = 1'b1;
    out_ready = 1'b1;
    p0 = pop_cnt;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("no_stale_pops", 64'(pop_cnt - p0), 64'd0);
    send(ALU_OP_XOR, 64'hA5A5, 64'h0F0F, 4'd13);
    in_valid = 1'b0;
    wait_drain();

    // Operand hold without accepts
    send(ALU_OP_XOR, 64'd5, 64'd3, 4'd6);
    in_valid = 1'b0;
    in_a = 64'd99;
    in_b = 64'd77;
    in_op = ALU_OP_ADD;
    for (int i = 0; i < 5; i++) begin
      check("hold_a", alu_a, 64'd5);
      check("hold_b", alu_b, 64'd3);
      check("hold_sel", 64'(alu_select), 64'(ALU_OP_XOR));
      @(posedge clk);
      #1;
    end
    wait_drain();
    check("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
